// File: rtl/spi_ram_slave_burst.sv
// SPI slave sampled on the system clock, in front of a single-port RAM.
// Frames are {cmd[1:0], payload}; SS_n held low chains frames into a burst.
module spi_ram_slave_burst #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              frame_abort
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0]  RX_LAST  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  TX_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RX, WAIT_TX, TX} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [FRAME_W-1:0]  rx_sh;
    logic [DATA_W-1:0]   tx_sh;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   rd_base;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [1:0]          cmd;
    logic [DATA_W-1:0]   payload;
    logic [ADDR_W-1:0]   pl_addr;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_en;

    assign cmd     = rx_data[FRAME_W-1 -: 2];
    assign payload = rx_data[DATA_W-1:0];
    assign pl_addr = payload[ADDR_W-1:0];
    // Addresses at or beyond DEPTH read as zero and drop writes.
    assign rd_word = ({1'b0, rd_addr} < DEPTH_X) ? mem[rd_addr] : '0;
    assign wr_en   = rx_valid && (cmd == 2'b01) && ({1'b0, wr_addr} < DEPTH_X);

    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] a);
        if (AUTO_INC == 0)
            return a;
        return (a == ADDR_TOP) ? '0 : a + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            rd_base     <= '0;
            MISO        <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            MISO        <= 1'b0;

            // Command side effects land on the edge that sees rx_valid high.
            if (rx_valid) begin
                case (cmd)
                    2'b00:   wr_addr <= pl_addr;
                    2'b01:   wr_addr <= bump(wr_addr);
                    2'b10:   rd_addr <= pl_addr;
                    default: begin
                        rd_base <= rd_addr;
                        rd_addr <= bump(rd_addr);
                    end
                endcase
            end

            case (state)
                IDLE: begin
                    cnt  <= '0;
                    busy <= !SS_n;
                    if (!SS_n)
                        state <= RX;
                end

                RX: begin
                    if (cnt == RX_LAST) begin
                        // All bits are in: the frame completes whatever SS_n does now.
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        cnt      <= '0;
                        if (rx_sh[FRAME_W-1 -: 2] == 2'b11) begin
                            state <= WAIT_TX;
                            busy  <= 1'b1;
                        end else begin
                            state <= SS_n ? IDLE : RX;
                            busy  <= !SS_n;
                        end
                    end else if (SS_n) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_abort <= (cnt != '0);
                    end else begin
                        rx_sh <= {rx_sh[FRAME_W-2:0], MOSI};
                        cnt   <= cnt + CNT_W'(1);
                    end
                end

                WAIT_TX: begin
                    if (SS_n) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_abort <= 1'b1;
                        rd_addr     <= rd_addr;  // cancel the post-increment landing this edge
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= rd_word;
                        tx_sh    <= rd_word;
                        cnt      <= '0;
                        state    <= TX;
                    end
                end

                TX: begin
                    if (SS_n) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_abort <= 1'b1;
                        rd_addr     <= rd_base;  // an aborted read can be retried at the same address
                    end else begin
                        MISO  <= tx_sh[DATA_W-1];
                        tx_sh <= tx_sh << 1;
                        if (cnt == TX_LAST) begin
                            state <= RX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Randomised bench for spi_ram_slave_burst: three builds (default, no auto-increment,
// 16-bit/1000-deep) driven frame by frame against an array-based RAM model.
module tb_spi_ram_slave_burst;

    logic clk = 1'b0;
    logic rst;
    logic ss_n [3];
    logic mosi [3];
    logic miso [3];
    logic rxv  [3];
    logic txv  [3];
    logic bsy  [3];
    logic abt  [3];
    logic [9:0]  rxd0, rxd1;
    logic [17:0] rxd2;
    logic [7:0]  txd0, txd1;
    logic [15:0] txd2;

    int checks = 0;
    int errors = 0;

    int dw   [3] = '{8, 8, 16};
    int aw   [3] = '{8, 8, 10};
    int dep  [3] = '{256, 256, 1000};
    int ainc [3] = '{1, 0, 1};

    int          wr_m  [3];
    int          rd_m  [3];
    logic [15:0] mem_m [3][1024];
    bit          kn_m  [3][1024];

    always #5 clk = ~clk;

    spi_ram_slave_burst #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]),
        .rx_valid(rxv[0]), .rx_data(rxd0), .tx_valid(txv[0]), .tx_data(txd0),
        .busy(bsy[0]), .frame_abort(abt[0]));

    spi_ram_slave_burst #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]),
        .rx_valid(rxv[1]), .rx_data(rxd1), .tx_valid(txv[1]), .tx_data(txd1),
        .busy(bsy[1]), .frame_abort(abt[1]));

    spi_ram_slave_burst #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .AUTO_INC(1)) dut2 (
        .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]),
        .rx_valid(rxv[2]), .rx_data(rxd2), .tx_valid(txv[2]), .tx_data(txd2),
        .busy(bsy[2]), .frame_abort(abt[2]));

    function automatic logic [17:0] rxd(int u);
        case (u)
            0:       return 18'(rxd0);
            1:       return 18'(rxd1);
            default: return rxd2;
        endcase
    endfunction

    function automatic logic [15:0] txd(int u);
        case (u)
            0:       return 16'(txd0);
            1:       return 16'(txd1);
            default: return txd2;
        endcase
    endfunction

    function automatic int next_addr(int u, int a);
        return (ainc[u] != 0) ? (a + 1) % dep[u] : a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(int u);
        ss_n[u] = 1'b0;
        tick();
    endtask

    task automatic end_burst(int u);
        ss_n[u] = 1'b1;
        mosi[u] = 1'b0;
        tick();
        checks++;
        if (bsy[u] !== 1'b0 || abt[u] !== 1'b0) begin
            errors++;
            $display("FAIL end_burst u%0d busy=%b abort=%b want 0 0", u, bsy[u], abt[u]);
        end
    endtask

    // One frame starting from the RX-ready point; for reads, takes tx_bits MISO bits
    // and aborts by raising SS_n if that is fewer than a full word.
    task automatic do_frame(int u, logic [1:0] cmd, int payload, int tx_bits);
        int          fw;
        int          pl;
        int          addr;
        int          rd_prev;
        logic [17:0] f;
        logic [15:0] exp_w;
        bit          kn;
        fw      = dw[u] + 2;
        pl      = payload & ((1 << dw[u]) - 1);
        addr    = pl % (1 << aw[u]);
        f       = (18'(cmd) << dw[u]) | 18'(pl);
        exp_w   = '0;
        kn      = 1'b0;
        rd_prev = rd_m[u];
        for (int i = 0; i < fw; i++) begin
            mosi[u] = f[fw-1-i];
            tick();
            checks++;
            if (rxv[u] !== 1'b0) begin
                errors++;
                $display("FAIL rx_early u%0d bit %0d rx_valid=%b want 0", u, i, rxv[u]);
            end
        end
        mosi[u] = 1'($urandom);
        tick();
        checks++;
        if (rxv[u] !== 1'b1 || rxd(u) !== f) begin
            errors++;
            $display("FAIL rx_frame u%0d rx_valid=%b rx_data=%h want 1 %h", u, rxv[u], rxd(u), f);
        end
        case (cmd)
            2'd0: wr_m[u] = addr;
            2'd1: begin
                mem_m[u][wr_m[u]] = 16'(pl);
                kn_m[u][wr_m[u]]  = 1'b1;
                wr_m[u]           = next_addr(u, wr_m[u]);
            end
            2'd2: rd_m[u] = addr;
            default: begin
                exp_w   = mem_m[u][rd_m[u]];
                kn      = kn_m[u][rd_m[u]];
                rd_prev = rd_m[u];
                rd_m[u] = next_addr(u, rd_m[u]);
            end
        endcase
        if (cmd == 2'd3) begin
            tick();
            checks++;
            if (txv[u] !== 1'b1 || rxv[u] !== 1'b0 || (kn && txd(u) !== exp_w)) begin
                errors++;
                $display("FAIL tx_load u%0d tx_valid=%b rx_valid=%b tx_data=%h want 1 0 %h",
                         u, txv[u], rxv[u], txd(u), exp_w);
            end
            for (int i = 0; i < tx_bits; i++) begin
                tick();
                checks++;
                if (kn && (miso[u] !== exp_w[dw[u]-1-i] || txv[u] !== 1'b0)) begin
                    errors++;
                    $display("FAIL miso u%0d bit %0d got %b want %b", u, i, miso[u], exp_w[dw[u]-1-i]);
                end
            end
            if (tx_bits < dw[u]) begin
                ss_n[u] = 1'b1;
                tick();
                checks++;
                if (abt[u] !== 1'b1 || miso[u] !== 1'b0 || rxv[u] !== 1'b0 || txv[u] !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_abort u%0d abort=%b miso=%b rxv=%b txv=%b want 1 0 0 0",
                             u, abt[u], miso[u], rxv[u], txv[u]);
                end
                rd_m[u] = rd_prev;
                tick();
                checks++;
                if (abt[u] !== 1'b0 || bsy[u] !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_abort_pulse u%0d abort=%b busy=%b want 0 0", u, abt[u], bsy[u]);
                end
            end
        end
    endtask

    task automatic abort_rx(int u, logic [1:0] cmd, int payload, int nb);
        logic [17:0] f;
        int          fw;
        fw = dw[u] + 2;
        f  = (18'(cmd) << dw[u]) | 18'(payload & ((1 << dw[u]) - 1));
        for (int i = 0; i < nb; i++) begin
            mosi[u] = f[fw-1-i];
            tick();
        end
        ss_n[u] = 1'b1;
        tick();
        checks++;
        if (abt[u] !== 1'b1 || rxv[u] !== 1'b0 || miso[u] !== 1'b0) begin
            errors++;
            $display("FAIL rx_abort u%0d abort=%b rxv=%b miso=%b want 1 0 0", u, abt[u], rxv[u], miso[u]);
        end
        tick();
        checks++;
        if (abt[u] !== 1'b0 || bsy[u] !== 1'b0 || rxv[u] !== 1'b0) begin
            errors++;
            $display("FAIL rx_abort_pulse u%0d abort=%b busy=%b rxv=%b want 0 0 0", u, abt[u], bsy[u], rxv[u]);
        end
    endtask

    task automatic check_idle_zero(string name);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (miso[u] !== 1'b0 || rxv[u] !== 1'b0 || txv[u] !== 1'b0 || bsy[u] !== 1'b0 ||
                abt[u] !== 1'b0 || rxd(u) !== 18'd0 || txd(u) !== 16'd0) begin
                errors++;
                $display("FAIL %s u%0d miso=%b rxv=%b txv=%b busy=%b abort=%b rxd=%h txd=%h want all 0",
                         name, u, miso[u], rxv[u], txv[u], bsy[u], abt[u], rxd(u), txd(u));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            ss_n[u] = 1'b1;
            mosi[u] = 1'b0;
            wr_m[u] = 0;
            rd_m[u] = 0;
        end
        repeat (3) tick();
        check_idle_zero("reset_state");
        rst = 1'b0;
        tick();
        start(0);
        for (int i = 0; i < 4; i++) begin
            mosi[0] = 1'($urandom);
            tick();
        end
        checks++;
        if (bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_rx got %b want 1", bsy[0]);
        end
        rst = 1'b1;
        tick();
        check_idle_zero("reset_mid_rx");
        ss_n[0] = 1'b1;
        rst     = 1'b0;
        tick();
        checks++;
        if (abt[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_abort abort=%b busy=%b want 0 0", abt[0], bsy[0]);
        end
        // addresses restart at 0 after reset
        start(0);
        do_frame(0, 2'd1, 'h3C, 8);
        do_frame(0, 2'd3, 0, 8);
        end_burst(0);
        checks++;
        if (txd0 !== 8'h3C) begin
            errors++;
            $display("FAIL reset_addr0 tx_data=%h want 3c", txd0);
        end
    endtask

    task automatic test_single();
        start(0); do_frame(0, 2'd0, 'h05, 8); end_burst(0);
        start(0); do_frame(0, 2'd1, 'hA5, 8); end_burst(0);
        start(0); do_frame(0, 2'd2, 'h05, 8); end_burst(0);
        start(0); do_frame(0, 2'd3, int'($urandom_range(0, 255)), 8); end_burst(0);
        checks++;
        if (txd0 !== 8'hA5) begin
            errors++;
            $display("FAIL single_read tx_data=%h want a5", txd0);
        end
    endtask

    task automatic test_burst();
        start(0);
        do_frame(0, 2'd0, 'hFE, 8);
        do_frame(0, 2'd1, 'h11, 8);
        do_frame(0, 2'd1, 'h22, 8);
        do_frame(0, 2'd1, 'h33, 8);
        end_burst(0);
        start(0);
        do_frame(0, 2'd2, 'hFE, 8);
        do_frame(0, 2'd3, 0, 8);
        do_frame(0, 2'd3, 0, 8);
        do_frame(0, 2'd3, 0, 8);
        end_burst(0);
        checks++;
        if (txd0 !== 8'h33) begin
            errors++;
            $display("FAIL burst_wrap tx_data=%h want 33", txd0);
        end
    endtask

    task automatic test_no_autoinc();
        start(1);
        do_frame(1, 2'd0, 'h11, 8);
        do_frame(1, 2'd1, 'h77, 8);
        do_frame(1, 2'd0, 'h10, 8);
        do_frame(1, 2'd1, 'h11, 8);
        do_frame(1, 2'd1, 'h22, 8);
        end_burst(1);
        start(1);
        do_frame(1, 2'd2, 'h10, 8);
        do_frame(1, 2'd3, 0, 8);
        do_frame(1, 2'd3, 0, 8);
        do_frame(1, 2'd2, 'h11, 8);
        do_frame(1, 2'd3, 0, 8);
        end_burst(1);
        checks++;
        if (txd1 !== 8'h77) begin
            errors++;
            $display("FAIL no_autoinc_neighbour tx_data=%h want 77", txd1);
        end
    endtask

    task automatic test_abort();
        start(0); do_frame(0, 2'd0, 'h40, 8); do_frame(0, 2'd1, 'h5A, 8); end_burst(0);
        start(0); abort_rx(0, 2'd1, 'hC3, 5);
        start(0); do_frame(0, 2'd1, 'h66, 8); end_burst(0);
        start(0);
        do_frame(0, 2'd2, 'h40, 8);
        do_frame(0, 2'd3, 0, 8);
        do_frame(0, 2'd3, 0, 8);
        end_burst(0);
        checks++;
        if (txd0 !== 8'h66) begin
            errors++;
            $display("FAIL abort_wr_addr tx_data=%h want 66", txd0);
        end
        start(0); do_frame(0, 2'd2, 'h40, 8); do_frame(0, 2'd3, 0, 3);
        start(0); do_frame(0, 2'd3, 0, 0);
        start(0); do_frame(0, 2'd3, 0, 8); end_burst(0);
        checks++;
        if (txd0 !== 8'h5A) begin
            errors++;
            $display("FAIL abort_rd_addr tx_data=%h want 5a", txd0);
        end
    endtask

    task automatic test_wide();
        start(2);
        do_frame(2, 2'd0, 999, 16);
        do_frame(2, 2'd1, 'hBEEF, 16);
        do_frame(2, 2'd1, 'h1234, 16);
        end_burst(2);
        start(2);
        do_frame(2, 2'd2, 999, 16);
        do_frame(2, 2'd3, 0, 16);
        checks++;
        if (txd2 !== 16'hBEEF) begin
            errors++;
            $display("FAIL wide_999 tx_data=%h want beef", txd2);
        end
        do_frame(2, 2'd3, 0, 16);
        end_burst(2);
        checks++;
        if (txd2 !== 16'h1234) begin
            errors++;
            $display("FAIL wide_wrap tx_data=%h want 1234", txd2);
        end
    endtask

    task automatic test_back_to_back();
        start(0);
        do_frame(0, 2'd0, 'h80, 8);
        do_frame(0, 2'd1, int'($urandom_range(0, 255)), 8);
        do_frame(0, 2'd1, int'($urandom_range(0, 255)), 8);
        do_frame(0, 2'd2, 'h80, 8);
        do_frame(0, 2'd3, 0, 8);
        do_frame(0, 2'd0, 'h90, 8);
        do_frame(0, 2'd1, int'($urandom_range(0, 255)), 8);
        do_frame(0, 2'd3, 0, 8);
        do_frame(0, 2'd2, 'h90, 8);
        do_frame(0, 2'd3, 0, 8);
        end_burst(0);
    endtask

    task automatic test_random();
        for (int rep = 0; rep < 9; rep++) begin
            int u;
            int base;
            int n;
            u    = rep % 3;
            base = int'($urandom_range(0, dep[u] - 1));
            n    = int'($urandom_range(2, 5));
            start(u);
            do_frame(u, 2'd0, base, dw[u]);
            for (int k = 0; k < n; k++)
                do_frame(u, 2'd1, int'($urandom), dw[u]);
            end_burst(u);
            repeat ($urandom_range(0, 3)) tick();
            start(u);
            do_frame(u, 2'd2, base, dw[u]);
            for (int k = 0; k < n; k++)
                do_frame(u, 2'd3, int'($urandom), dw[u]);
            end_burst(u);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_no_autoinc();
        test_abort();
        test_wide();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
